// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment driver with per-digit blink and leading-zero
// blanking. Enables, segments and the frame tick all come from output registers.
module seven_segment_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [DIGITS-1:0]     seven_enable,
  output logic                  A,
  output logic                  B,
  output logic                  C,
  output logic                  D,
  output logic                  E,
  output logic                  F,
  output logic                  G,
  output logic                  frame_tick
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [DIGITS-1:0] drive_en(input logic [DIGITS-1:0] e);
    return ACTIVE_LOW ? ~e : e;
  endfunction

  function automatic logic [6:0] drive_seg(input logic [6:0] s);
    return ACTIVE_LOW ? ~s : s;
  endfunction

  logic [RW-1:0]       refresh_cnt;
  logic [BW-1:0]       blink_cnt;
  logic [IW-1:0]       digit_idx;
  logic                blink_phase;
  logic                refresh_wrap;
  logic                scan_wrap;

  logic [4*DIGITS-1:0] value_p0;
  logic                lz_p0;
  logic [DIGITS-1:0]   blink_p0;

  logic                zero_run;
  logic [DIGITS-1:0]   lz_dark;
  logic [DIGITS-1:0]   sel;
  logic [3:0]          nibble;
  logic                dark;
  logic [DIGITS-1:0]   enable_hi;
  logic [6:0]          seg_hi;

  logic [DIGITS-1:0]   enable_p1;
  logic [6:0]          seg_p1;
  logic                tick_p1;

  assign refresh_wrap = (refresh_cnt == REF_LAST);
  assign scan_wrap    = refresh_wrap && (digit_idx == IDX_LAST);

  // Scan and blink timing
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      blink_cnt   <= '0;
      digit_idx   <= '0;
      blink_phase <= 1'b1;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
      if (refresh_wrap)
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Stage p0: shadow registers captured on load
  always_ff @(posedge clk) begin
    if (reset) begin
      value_p0 <= '0;
      lz_p0    <= 1'b0;
      blink_p0 <= '0;
    end else if (load) begin
      value_p0 <= value;
      lz_p0    <= lz_en;
      blink_p0 <= blink_en;
    end
  end

  // A digit is blanked when it and every higher nibble are zero; digit 0 never is.
  always_comb begin
    zero_run = 1'b1;
    lz_dark  = '0;
    sel      = '0;
    nibble   = 4'h0;
    dark     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (value_p0[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_run & (i > 0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        sel[i] = 1'b1;
        nibble = value_p0[4*i +: 4];
        dark   = (lz_p0 & lz_dark[i]) | (blink_p0[i] & ~blink_phase);
      end
    end
    enable_hi = dark ? '0 : sel;
    seg_hi    = dark ? 7'h00 : hex_to_seg(nibble);
  end

  // Stage p1: registered outputs with polarity applied
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_p1 <= drive_en('0);
      seg_p1    <= drive_seg(7'h00);
      tick_p1   <= 1'b0;
    end else begin
      enable_p1 <= drive_en(enable_hi);
      seg_p1    <= drive_seg(seg_hi);
      tick_p1   <= scan_wrap;
    end
  end

  assign seven_enable = enable_p1;
  assign {G, F, E, D, C, B, A} = seg_p1;
  assign frame_tick = tick_p1;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan: reset, scan order, leading-zero
// blanking, blink phases, reset mid-scan and a mid-slot reload.
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        lz_en;
  logic [3:0]  blink_en;
  logic [3:0]  seven_enable;
  logic        A, B, C, D, E, F, G;
  logic        frame_tick;
  logic [6:0]  seg;

  int n;
  int checks;
  int passed;

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_segment_scan #(
    .DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(32), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .lz_en(lz_en),
    .blink_en(blink_en), .seven_enable(seven_enable),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  assign seg = {G, F, E, D, C, B, A};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at n=%0d: observed %h expected %h", tag, n, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  // n = edges since the reset edge; outputs after edge n reflect state before it,
  // i.e. slot m=n-1: digit (m/4)%4, blink visible while (m/32) is even.
  task automatic check_model(input logic [15:0] v, input logic lz, input logic [3:0] bl);
    int m, d;
    logic vis, drk;
    logic [3:0] nib, en;
    logic [6:0] sg;
    m   = n - 1;
    d   = (m / 4) % 4;
    vis = ((m / 32) % 2) == 0;
    drk = (bl[d] && !vis) || (lz && d > 0 && (v >> (4 * d)) == 16'h0);
    nib = v[4*d +: 4];
    en  = drk ? 4'b1111 : ~(4'b0001 << d);
    sg  = drk ? 7'h7F : ~segtab[nib];
    chk("enable", {4'h0, seven_enable}, {4'h0, en});
    chk("segments", {1'b0, seg}, {1'b0, sg});
    chk("frame_tick", {7'h0, frame_tick}, {7'h0, (n % 16) == 0});
  endtask

  task automatic start(input logic [15:0] v, input logic lz, input logic [3:0] bl);
    reset = 1'b1;
    step();
    reset    = 1'b0;
    load     = 1'b1;
    value    = v;
    lz_en    = lz;
    blink_en = bl;
    n = 0;
    step();
    load = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    n = 0;
    reset = 1'b1; load = 1'b0; value = 16'h0; lz_en = 1'b0; blink_en = 4'h0;
    repeat (3) step();
    chk("reset_enable", {4'h0, seven_enable}, 8'h0F);
    chk("reset_segments", {1'b0, seg}, 8'h7F);
    chk("reset_tick", {7'h0, frame_tick}, 8'h00);

    // 0x1234: first update still shows the cleared shadow, then '4' on digit 0
    reset = 1'b0; load = 1'b1; value = 16'h1234; n = 0;
    step();
    load = 1'b0;
    chk("first_enable", {4'h0, seven_enable}, 8'h0E);
    chk("first_segments", {1'b0, seg}, 8'h40);
    step();
    chk("digit0_enable", {4'h0, seven_enable}, 8'h0E);
    chk("digit0_four", {1'b0, seg}, 8'h19);
    chk("digit0_tick", {7'h0, frame_tick}, 8'h00);
    while (n < 36) begin
      step();
      check_model(16'h1234, 1'b0, 4'h0);
    end

    // Leading-zero blanking on 0x0050
    start(16'h0050, 1'b1, 4'h0);
    while (n < 17) begin
      step();
      check_model(16'h0050, 1'b1, 4'h0);
      if (n == 6) chk("lz_digit1_five", {1'b0, seg}, 8'h12);
      if (n == 10) chk("lz_digit2_dark", {4'h0, seven_enable}, 8'h0F);
    end

    // All-zero value: only digit 0 remains
    start(16'h0000, 1'b1, 4'h0);
    while (n < 17) begin
      step();
      check_model(16'h0000, 1'b1, 4'h0);
      if (n == 2) chk("zero_digit0", {1'b0, seg}, 8'h40);
      if (n == 14) chk("zero_digit3_dark", {1'b0, seg}, 8'h7F);
    end

    // Blink on digit 0 across two phase toggles
    start(16'h1234, 1'b0, 4'b0001);
    while (n < 80) begin
      step();
      check_model(16'h1234, 1'b0, 4'b0001);
      if (n == 34) chk("blink_dark", {4'h0, seven_enable}, 8'h0F);
      if (n == 38) chk("blink_digit1", {1'b0, seg}, 8'h30);
      if (n == 66) chk("blink_lit_again", {1'b0, seg}, 8'h19);
    end

    // Reset during digit 2 (with load asserted, which reset must override)
    start(16'h1234, 1'b0, 4'h0);
    while (n < 10) begin
      step();
      check_model(16'h1234, 1'b0, 4'h0);
    end
    reset = 1'b1; load = 1'b1; value = 16'hFFFF;
    step();
    chk("midreset_enable", {4'h0, seven_enable}, 8'h0F);
    chk("midreset_segments", {1'b0, seg}, 8'h7F);
    chk("midreset_tick", {7'h0, frame_tick}, 8'h00);
    reset = 1'b0; load = 1'b0; n = 0;
    while (n < 20) begin
      step();
      check_model(16'h0000, 1'b0, 4'h0);
    end

    // Reload 0xABCD in the middle of digit 1's slot
    start(16'h1234, 1'b0, 4'h0);
    while (n < 6) begin
      step();
      check_model(16'h1234, 1'b0, 4'h0);
    end
    load = 1'b1; value = 16'hABCD;
    step();
    load = 1'b0;
    check_model(16'h1234, 1'b0, 4'h0);
    step();
    chk("reload_enable", {4'h0, seven_enable}, 8'h0D);
    chk("reload_c", {1'b0, seg}, 8'h46);
    while (n < 24) begin
      step();
      check_model(16'hABCD, 1'b0, 4'h0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
